fp_mult_pipe: RTL and testbench
===============================

// Module: fp_mult_pipe
// PURPOSE
//  Pipelined, parametrised IEEE-754-style floating-point multiplier. Successor to the
//  combinational FP16 multiply in the datapath. Adds configurable exponent/mantissa
//  widths, full subnormal support, NaN handling, round-to-nearest-even and exception
//  flags. Uses a valid/ready stream interface and sits between the operand-issue
//  stage and the writeback buffer.
// PARAMETERS
//  EXP_W  5   exponent field width; BIAS = 2^(EXP_W-1)-1
//  MAN_W  10  stored mantissa (fraction) width; word width W = 1+EXP_W+MAN_W
// PORTS
//  clk        in   1  single clock; all state is updated on the rising edge
//  rst_n      in   1  reset, asynchronous, active-low
//  in_valid   in   1  operand pair {a,b} is valid
//  in_ready   out  1  block accepts the pair this cycle (in_valid && in_ready)
//  a          in   W  operand A: {sign, exp, frac}
//  b          in   W  operand B: {sign, exp, frac}
//  out_valid  out  1  prod and flags are valid
//  out_ready  in   1  consumer takes the result this cycle
//  prod       out  W  rounded product
//  flag_ovf   out  1  overflow: finite result rounded to infinity
//  flag_unf   out  1  underflow: result tiny (subnormal or zero) and inexact
//  flag_inx   out  1  inexact: rounding discarded nonzero bits
//  flag_inv   out  1  invalid: inf*0, or any NaN operand
// BEHAVIOUR
//  Reset: all stage-valid bits, out_valid, prod and all flags are 0. Reset may be
//   asserted mid-operation; in-flight results are discarded and none is emitted.
//  Pipeline: S1 unpack/classify (implicit 1, or 0 when exp=0); S2 (MAN_W+1)^2
//   multiply, sign = XOR, exponent sum minus BIAS; S3 normalise, round, pack, flags.
//  Latency: exactly 3 cycles from input handshake to out_valid when no stall.
//   Throughput: 1 result per cycle.
//  Flow control: advance = out_ready || !out_valid. The whole pipe holds when
//   advance=0. in_ready = advance. Bubbles are not squeezed out. Results stay in
//   order; none is dropped or duplicated. prod and flags stay stable while
//   out_valid && !out_ready.
//  Special cases (checked in S1, forced in S3):
//   - NaN (exp all 1s, frac!=0) on either input -> canonical qNaN
//     {0, all 1s, 1, 0...}, flag_inv=1.
//   - inf*0 -> canonical qNaN, flag_inv=1.
//   - inf*finite nonzero -> inf with XOR sign; no flags.
//   - zero*finite -> signed zero (XOR); no flags.
//  Normalisation: subnormal products are left-shifted by the leading-zero count,
//   and the exponent is decremented per shift. Shifting stops when the biased
//   exponent reaches 1; the result is then subnormal (exp field 0). Results below
//   exponent 1 are right-shifted, and the lost bits go into sticky.
//  Rounding: round-to-nearest-even using guard, round and sticky (OR of all lower
//   bits). A mantissa carry-out increments the exponent. Rounding up out of the
//   largest subnormal produces the smallest normal.
//  Overflow: biased exponent >= 2^EXP_W-1 after rounding -> inf with XOR sign,
//   flag_ovf=1 and flag_inx=1.
//  Underflow: flag_unf=1 only when the result is tiny AND flag_inx=1. Exact
//   subnormal results raise no flag.
//  Flags are per-result. They are valid with out_valid and are not sticky across
//   results.
// TESTING (EXP_W=5, MAN_W=10)
//  1. 3C00*3C00 -> 3C00, no flags. 4080*3C80 -> 4110, no flags. C000*4000 -> C400.
//  2. Overflow: 7BFF*7BFF -> 7C00, ovf=1, inx=1. 7C00*BC00 -> FC00, no flags.
//  3. Invalid: 7C00*0000 -> 7E00, inv=1. 7E01*3C00 -> 7E00, inv=1.
//     8000*3C00 -> 8000, no flags.
//  4. Subnormal: 4000*0001 -> 0002 exact, no flags. 0001*3800 -> 0000 (tie to
//     even), unf=1, inx=1. 0001*3E00 -> 0002 (round up), unf=1, inx=1.
//  5. Backpressure: stream 6 pairs with out_ready=0 -> in_ready drops once 3
//     results are held. Release out_ready -> all 6 results emerge in order,
//     values unchanged.
//  6. Reset: assert rst_n=0 with 2 results in flight -> out_valid=0 immediately.
//     After release, the first new input appears exactly 3 cycles after its
//     handshake.

Source files
------------

// File: rtl/fp_mult_pipe.sv
// rtl/fp_mult_pipe.sv - three-stage pipelined floating-point multiplier with RNE rounding
module fp_mult_pipe #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   prod,
    output logic                   flag_ovf,
    output logic                   flag_unf,
    output logic                   flag_inx,
    output logic                   flag_inv
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int PW   = 2 * (MAN_W + 1);
    localparam int EW   = EXP_W + 3;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam logic [EXP_W-1:0]        EXP_MAX = '1;
    localparam logic signed [EW-1:0]    EXP_INF = EW'((1 << EXP_W) - 1);

    logic advance;
    assign advance  = out_ready || !out_valid;
    assign in_ready = advance;

    // S1: classify operands and restore the implicit leading bit
    logic a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
    always_comb begin
        a_nan  = (a[W-2:MAN_W] == EXP_MAX) && (a[MAN_W-1:0] != '0);
        a_inf  = (a[W-2:MAN_W] == EXP_MAX) && (a[MAN_W-1:0] == '0);
        a_zero = (a[W-2:MAN_W] == '0) && (a[MAN_W-1:0] == '0);
        b_nan  = (b[W-2:MAN_W] == EXP_MAX) && (b[MAN_W-1:0] != '0);
        b_inf  = (b[W-2:MAN_W] == EXP_MAX) && (b[MAN_W-1:0] == '0);
        b_zero = (b[W-2:MAN_W] == '0) && (b[MAN_W-1:0] == '0);
    end

    logic             s1_valid, s1_sign, s1_inv, s1_inf, s1_zero;
    logic [EXP_W-1:0] s1_ea, s1_eb;
    logic [MAN_W:0]   s1_ma, s1_mb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_inv   <= 1'b0;
            s1_inf   <= 1'b0;
            s1_zero  <= 1'b0;
            s1_ea    <= '0;
            s1_eb    <= '0;
            s1_ma    <= '0;
            s1_mb    <= '0;
        end else if (advance) begin
            s1_valid <= in_valid;
            s1_sign  <= a[W-1] ^ b[W-1];
            s1_inv   <= a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf);
            s1_inf   <= a_inf | b_inf;
            s1_zero  <= a_zero | b_zero;
            s1_ea    <= (a[W-2:MAN_W] == '0) ? EXP_W'(1) : a[W-2:MAN_W];
            s1_eb    <= (b[W-2:MAN_W] == '0) ? EXP_W'(1) : b[W-2:MAN_W];
            s1_ma    <= {a[W-2:MAN_W] != '0, a[MAN_W-1:0]};
            s1_mb    <= {b[W-2:MAN_W] != '0, b[MAN_W-1:0]};
        end
    end

    // S2: the exponent is biased for a binary point just below the product MSB
    logic                 s2_valid, s2_sign, s2_inv, s2_inf, s2_zero;
    logic signed [EW-1:0] s2_e;
    logic [PW-1:0]        s2_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_inv   <= 1'b0;
            s2_inf   <= 1'b0;
            s2_zero  <= 1'b0;
            s2_e     <= '0;
            s2_p     <= '0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            s2_sign  <= s1_sign;
            s2_inv   <= s1_inv;
            s2_inf   <= s1_inf;
            s2_zero  <= s1_zero;
            s2_e     <= EW'(s1_ea) + EW'(s1_eb) - EW'(BIAS - 1);
            s2_p     <= PW'(s1_ma) * PW'(s1_mb);
        end
    end

    // S3: normalise (left shift bounded by exponent 1, or right shift into sticky)
    int                   lz, ls, rs;
    logic [2*PW-1:0]      rsh;
    logic [PW-1:0]        pn;
    logic signed [EW-1:0] en, exp_r;
    logic [MAN_W:0]       mant;
    logic [MAN_W+1:0]     mant_r;
    logic [MAN_W-1:0]     frac;
    logic                 guard, rnd, sticky, sticky_rs, rup, inexact, ovf;
    logic [W-1:0]         prod_n;
    logic [3:0]           flags_n;

    always_comb begin
        lz = PW;
        for (int i = 0; i < PW; i++) begin
            if (s2_p[i]) lz = PW - 1 - i;
        end
        ls        = 0;
        rs        = 0;
        rsh       = '0;
        sticky_rs = 1'b0;
        if (s2_e < EW'(1)) begin
            rs = 1 - int'(s2_e);
            if (rs > PW) rs = PW;
            rsh       = {s2_p, {PW{1'b0}}} >> rs;
            pn        = rsh[2*PW-1:PW];
            sticky_rs = |rsh[PW-1:0];
            en        = EW'(1);
        end else begin
            ls = int'(s2_e) - 1;
            if (lz < ls) ls = lz;
            pn = s2_p << ls;
            en = s2_e - EW'(ls);
        end

        mant    = pn[PW-1:PW-1-MAN_W];
        guard   = pn[PW-2-MAN_W];
        rnd     = pn[PW-3-MAN_W];
        sticky  = (|pn[PW-4-MAN_W:0]) | sticky_rs;
        rup     = guard & (rnd | sticky | mant[0]);
        inexact = guard | rnd | sticky;
        mant_r  = {1'b0, mant} + (MAN_W+2)'(rup);

        // A subnormal that rounds into the hidden-bit position becomes exponent 1
        if (mant_r[MAN_W+1]) begin
            exp_r = en + EW'(1);
            frac  = mant_r[MAN_W:1];
        end else begin
            exp_r = mant_r[MAN_W] ? en : '0;
            frac  = mant_r[MAN_W-1:0];
        end
        ovf = (exp_r >= EXP_INF);

        flags_n = 4'b0000;
        if (s2_inv) begin
            prod_n     = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};
            flags_n[0] = 1'b1;
        end else if (s2_inf) begin
            prod_n = {s2_sign, EXP_MAX, {MAN_W{1'b0}}};
        end else if (s2_zero) begin
            prod_n = {s2_sign, {(W-1){1'b0}}};
        end else if (ovf) begin
            prod_n  = {s2_sign, EXP_MAX, {MAN_W{1'b0}}};
            flags_n = 4'b1010;
        end else begin
            prod_n  = {s2_sign, exp_r[EXP_W-1:0], frac};
            flags_n = {1'b0, inexact && (exp_r == '0), inexact, 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            prod      <= '0;
            flag_ovf  <= 1'b0;
            flag_unf  <= 1'b0;
            flag_inx  <= 1'b0;
            flag_inv  <= 1'b0;
        end else if (advance) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                prod     <= prod_n;
                flag_ovf <= flags_n[3];
                flag_unf <= flags_n[2];
                flag_inx <= flags_n[1];
                flag_inv <= flags_n[0];
            end
        end
    end
endmodule

// File: tb/tb_fp_mult_pipe.sv
// tb/tb_fp_mult_pipe.sv - self-checking bench for fp_mult_pipe (FP16 configuration)
module tb_fp_mult_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        in_ready, out_valid, flag_ovf, flag_unf, flag_inx, flag_inv;
    logic [15:0] prod;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          pop_cyc = -100;
    bit          rand_ready = 1'b0;
    logic [19:0] q[$];
    logic [19:0] pending = '0;

    // {a, b, expected {ovf,unf,inx,inv,prod}}
    localparam int NV = 12;
    localparam logic [15:0] VA [NV] = '{16'h3C00, 16'h4080, 16'hC000, 16'h7BFF, 16'h7C00, 16'h7C00,
                                        16'h7E01, 16'h8000, 16'h4000, 16'h0001, 16'h0001, 16'h03FF};
    localparam logic [15:0] VB [NV] = '{16'h3C00, 16'h3C80, 16'h4000, 16'h7BFF, 16'hBC00, 16'h0000,
                                        16'h3C00, 16'h3C00, 16'h0001, 16'h3800, 16'h3E00, 16'h3C01};
    localparam logic [19:0] VE [NV] = '{20'h03C00, 20'h04110, 20'h0C400, 20'hA7C00, 20'h0FC00, 20'h17E00,
                                        20'h17E00, 20'h08000, 20'h00002, 20'h60000, 20'h60002, 20'h20400};

    fp_mult_pipe #(.EXP_W(5), .MAN_W(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .prod      (prod),
        .flag_ovf  (flag_ovf),
        .flag_unf  (flag_unf),
        .flag_inx  (flag_inx),
        .flag_inv  (flag_inv)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Exact value is P * 2^E; round to the nearest multiple of the result quantum.
    function automatic logic [19:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
        int     ex, ey, kx, ky, e, k, xe, qe, d, expf;
        longint mx, my, p, n, rem, half;
        logic   s;
        bit     xn, xi, xz, yn, yi, yz, inx;
        ex = int'(x[14:10]);
        ey = int'(y[14:10]);
        s  = x[15] ^ y[15];
        xn = (ex == 31) && (x[9:0] != 0);
        xi = (ex == 31) && (x[9:0] == 0);
        xz = (ex == 0) && (x[9:0] == 0);
        yn = (ey == 31) && (y[9:0] != 0);
        yi = (ey == 31) && (y[9:0] == 0);
        yz = (ey == 0) && (y[9:0] == 0);
        if (xn || yn || (xi && yz) || (xz && yi)) return {4'b0001, 16'h7E00};
        if (xi || yi) return {4'b0000, s, 15'h7C00};
        if (xz || yz) return {4'b0000, s, 15'h0000};
        mx = (ex == 0) ? longint'(x[9:0]) : longint'(x[9:0]) + 1024;
        my = (ey == 0) ? longint'(y[9:0]) : longint'(y[9:0]) + 1024;
        kx = (ex == 0) ? -24 : ex - 25;
        ky = (ey == 0) ? -24 : ey - 25;
        p  = mx * my;
        e  = kx + ky;
        k  = 0;
        for (int i = 0; i < 24; i++) if (p[i]) k = i;
        xe = k + e;
        qe = (xe - 10 > -24) ? xe - 10 : -24;
        if (e >= qe) begin
            n   = p << (e - qe);
            rem = 0;
        end else begin
            d    = qe - e;
            n    = p >> d;
            rem  = p - (n << d);
            half = longint'(1) << (d - 1);
            if (rem > half || (rem == half && n[0])) n++;
        end
        inx = (rem != 0);
        if (n == 2048) begin
            n = 1024;
            qe++;
        end
        if (n >= 1024) begin
            expf = qe + 25;
            n    = n - 1024;
        end else begin
            expf = 0;
        end
        if (expf >= 31) return {4'b1010, s, 15'h7C00};
        return {1'b0, inx && (expf == 0), inx, 1'b0, s, 5'(expf), 10'(n)};
    endfunction

    function automatic logic [15:0] rnd_op();
        logic [9:0] f;
        logic [4:0] e;
        int         c;
        f = 10'($urandom);
        c = int'($urandom_range(0, 15));
        if (c == 0) e = 5'd0;
        else if (c == 1) begin e = 5'd0; f = 10'd0; end
        else if (c == 2) e = 5'd31;
        else if (c == 3) begin e = 5'd31; f = 10'd0; end
        else if (c < 8) e = 5'($urandom_range(1, 12));
        else e = 5'($urandom_range(1, 30));
        return {1'($urandom), e, f};
    endfunction

    task automatic chk(input string tag, input logic [19:0] got, input logic [19:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(output bit acc);
        @(negedge clk);
        acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            checks++;
            assert (q.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_output got=%h exp=none", prod);
            end
            if (q.size() != 0) chk("result", {flag_ovf, flag_unf, flag_inx, flag_inv, prod}, q.pop_front());
            pop_cyc = cyc;
        end
        if (acc) begin
            q.push_back(pending);
            acc_cyc = cyc;
        end
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [19:0] e);
        bit acc;
        acc      = 1'b0;
        a        = x;
        b        = y;
        pending  = e;
        in_valid = 1'b1;
        for (int n = 0; n < 200 && !acc; n++) tick(acc);
        chk("accept", 20'(acc), 20'd1);
    endtask

    task automatic drain();
        bit acc;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 100 && q.size() != 0; n++) tick(acc);
        chk("drain_left", 20'(q.size()), 20'd0);
    endtask

    initial begin
        bit          acc;
        logic [15:0] x, y;
        int          c0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", 20'(out_valid), 20'd0);
        chk("reset_prod", {flag_ovf, flag_unf, flag_inx, flag_inv, prod}, 20'd0);
        rst_n     = 1'b1;
        out_ready = 1'b1;

        for (int i = 0; i < NV; i++) send(VA[i], VB[i], VE[i]);
        drain();

        // backpressure: three results fill the pipe, the fourth pair must wait
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(VA[i], VB[i], VE[i]);
        chk("bp_in_ready", 20'(in_ready), 20'd0);
        chk("bp_out_valid", 20'(out_valid), 20'd1);
        a        = VA[3];
        b        = VB[3];
        pending  = VE[3];
        in_valid = 1'b1;
        repeat (3) begin
            tick(acc);
            chk("bp_stall", 20'(acc), 20'd0);
            chk("bp_hold", {flag_ovf, flag_unf, flag_inx, flag_inv, prod}, q[0]);
        end
        out_ready = 1'b1;
        for (int i = 3; i < 6; i++) send(VA[i], VB[i], VE[i]);
        drain();

        // reset with two results in flight discards them
        out_ready = 1'b0;
        send(VA[6], VB[6], VE[6]);
        send(VA[7], VB[7], VE[7]);
        in_valid = 1'b0;
        tick(acc);
        chk("pre_reset_valid", 20'(out_valid), 20'd1);
        rst_n = 1'b0;
        #1;
        chk("midreset_valid", 20'(out_valid), 20'd0);
        chk("midreset_prod", {flag_ovf, flag_unf, flag_inx, flag_inv, prod}, 20'd0);
        q.delete();
        #2;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (6) tick(acc);

        send(VA[8], VB[8], VE[8]);
        c0       = acc_cyc;
        in_valid = 1'b0;
        for (int n = 0; n < 10 && q.size() != 0; n++) tick(acc);
        chk("latency", 20'(pop_cyc - c0), 20'd3);

        rand_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            x = rnd_op();
            y = rnd_op();
            send(x, y, ref_mul(x, y));
            if ($urandom_range(0, 7) == 0) begin
                in_valid = 1'b0;
                tick(acc);
            end
        end
        rand_ready = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
